// File: rtl/dispensador_pedido.sv
// Purchase-finalisation responder: validates a request, runs the product motor, then pays change.
// Ports: i_clk/i_rst_n, i_req/i_prod_id/i_troco/i_estoque_vazio in; o_ack/o_ocupado/o_motor_en/o_moeda_sel/o_moeda_pulso/o_concluido/o_erro out.
module dispensador_pedido #(
  parameter int N_PROD  = 4,
  parameter int T_MOTOR = 8,
  parameter int T_MOEDA = 4,
  parameter int T_PAUSA = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic [2:0]        i_prod_id,
  input  logic [7:0]        i_troco,
  input  logic [N_PROD-1:0] i_estoque_vazio,
  output logic              o_ack,
  output logic              o_ocupado,
  output logic [N_PROD-1:0] o_motor_en,
  output logic [2:0]        o_moeda_sel,
  output logic              o_moeda_pulso,
  output logic              o_concluido,
  output logic              o_erro
);

  typedef enum logic [2:0] {
    S_OCIOSO,
    S_VALIDA,
    S_MOTOR,
    S_MOEDA,
    S_PAUSA,
    S_FIM,
    S_ERRO
  } state_t;

  localparam logic [7:0] L_MOTOR = 8'(T_MOTOR - 1);
  localparam logic [7:0] L_MOEDA = 8'(T_MOEDA - 1);
  localparam logic [7:0] L_PAUSA = 8'(T_PAUSA - 1);
  localparam logic [3:0] L_NPROD = 4'(N_PROD);

  state_t            r_state;
  state_t            w_state_n;
  logic [7:0]        r_cnt;
  logic [7:0]        w_cnt_n;
  logic [7:0]        r_rem;
  logic [7:0]        w_rem_n;
  logic [2:0]        r_prod;
  logic [2:0]        w_prod_n;
  logic [2:0]        r_sel;
  logic [2:0]        w_sel_n;
  logic              r_req_d;

  logic              r_ack;
  logic              r_ocupado;
  logic [N_PROD-1:0] r_motor;
  logic              r_pulso;
  logic              r_concluido;
  logic              r_erro;

  logic [N_PROD-1:0] w_onehot;
  logic              w_invalid;
  logic [2:0]        w_coin_sel;
  logic [7:0]        w_coin_val;

  // Out-of-range ids shift the bit out, leaving an all-zero mask.
  assign w_onehot =
    {{(N_PROD-1){1'b0}}, 1'b1} << r_prod;

  assign w_invalid =
    ({1'b0, r_prod} >= L_NPROD) ||
    (|(i_estoque_vazio & w_onehot)) ||
    ((r_rem % 8'd5) != 8'd0);

  // Largest coin not exceeding what is still owed.
  always_comb begin
    w_coin_sel = 3'd0;
    unique case (1'b1)
      (r_rem >= 8'd100):
        w_coin_sel = 3'd4;
      (r_rem >= 8'd50) && (r_rem < 8'd100):
        w_coin_sel = 3'd3;
      (r_rem >= 8'd25) && (r_rem < 8'd50):
        w_coin_sel = 3'd2;
      (r_rem >= 8'd10) && (r_rem < 8'd25):
        w_coin_sel = 3'd1;
      (r_rem < 8'd10):
        w_coin_sel = 3'd0;
    endcase
  end

  always_comb begin
    w_coin_val = 8'd5;
    unique case (r_sel)
      3'd4:    w_coin_val = 8'd100;
      3'd3:    w_coin_val = 8'd50;
      3'd2:    w_coin_val = 8'd25;
      3'd1:    w_coin_val = 8'd10;
      default: w_coin_val = 8'd5;
    endcase
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_rem_n   = r_rem;
    w_prod_n  = r_prod;
    w_sel_n   = r_sel;
    unique case (r_state)
      S_OCIOSO: begin
        if (i_req && !r_req_d) begin
          w_state_n = S_VALIDA;
          w_prod_n  = i_prod_id;
          w_rem_n   = i_troco;
        end
      end
      S_VALIDA: begin
        w_cnt_n = 8'd0;
        if (w_invalid)
          w_state_n = S_ERRO;
        else
          w_state_n = S_MOTOR;
      end
      S_MOTOR: begin
        if (r_cnt == L_MOTOR) begin
          w_cnt_n = 8'd0;
          if (r_rem == 8'd0) begin
            w_state_n = S_FIM;
          end else begin
            w_state_n = S_MOEDA;
            w_sel_n   = w_coin_sel;
          end
        end else begin
          w_cnt_n = r_cnt + 8'd1;
        end
      end
      S_MOEDA: begin
        if (r_cnt == L_MOEDA) begin
          w_cnt_n   = 8'd0;
          w_rem_n   = r_rem - w_coin_val;
          w_state_n = S_PAUSA;
        end else begin
          w_cnt_n = r_cnt + 8'd1;
        end
      end
      S_PAUSA: begin
        if (r_cnt == L_PAUSA) begin
          w_cnt_n = 8'd0;
          if (r_rem != 8'd0) begin
            w_state_n = S_MOEDA;
            w_sel_n   = w_coin_sel;
          end else begin
            w_state_n = S_FIM;
          end
        end else begin
          w_cnt_n = r_cnt + 8'd1;
        end
      end
      S_FIM:   w_state_n = S_OCIOSO;
      S_ERRO:  w_state_n = S_OCIOSO;
      default: w_state_n = S_OCIOSO;
    endcase
  end

  // Outputs are decoded from the next state and registered,
  // so they line up with the state they describe.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_OCIOSO;
      r_cnt       <= 8'd0;
      r_rem       <= 8'd0;
      r_prod      <= 3'd0;
      r_sel       <= 3'd0;
      r_req_d     <= 1'b1;
      r_ack       <= 1'b0;
      r_ocupado   <= 1'b0;
      r_motor     <= '0;
      r_pulso     <= 1'b0;
      r_concluido <= 1'b0;
      r_erro      <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_rem       <= w_rem_n;
      r_prod      <= w_prod_n;
      r_sel       <= w_sel_n;
      r_req_d     <= i_req;
      r_ack       <= (w_state_n == S_VALIDA);
      r_ocupado   <= (w_state_n != S_OCIOSO);
      r_motor     <= (w_state_n == S_MOTOR)
                     ? w_onehot : '0;
      r_pulso     <= (w_state_n == S_MOEDA);
      r_concluido <= (w_state_n == S_FIM);
      r_erro      <= (w_state_n == S_ERRO);
    end
  end

  assign o_ack         = r_ack;
  assign o_ocupado     = r_ocupado;
  assign o_motor_en    = r_motor;
  assign o_moeda_sel   = r_sel;
  assign o_moeda_pulso = r_pulso;
  assign o_concluido   = r_concluido;
  assign o_erro        = r_erro;

endmodule
